// File: rtl/pc_seq_stack.sv
// pc_seq_stack: program sequencer with programmable branch-target LUT, return stack and start/done/fault handshake
module pc_seq_stack #(
    parameter int PC_W      = 8,
    parameter int LUT_AW    = 2,
    parameter int STK_DEPTH = 4,
    parameter int SP_W      = $clog2(STK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              br_rel,
    input  logic              br_abs,
    input  logic              call,
    input  logic              ret,
    input  logic              halt,
    input  logic [LUT_AW-1:0] sel,
    input  logic              z,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   PC,
    output logic              running,
    output logic              done,
    output logic              err,
    output logic [SP_W-1:0]   sp_lvl
);
    localparam int SA_W = STK_DEPTH > 1 ? $clog2(STK_DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;
    state_t state, state_n;
    logic [PC_W-1:0] lut [2**LUT_AW];
    logic [PC_W-1:0] stk [STK_DEPTH];
    logic [SP_W-1:0] sp, sp_n;
    logic [PC_W-1:0] pc_n, pc_inc, tgt;
    logic push;
    assign pc_inc = PC + 1'b1;
    assign tgt    = lut[sel];
    assign sp_lvl = sp;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            PC    <= '0;
            sp    <= '0;
            for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= '0;
            for (int i = 0; i < STK_DEPTH; i++) stk[i] <= '0;
        end else begin
            state <= state_n;
            PC    <= pc_n;
            sp    <= sp_n;
            if (lut_we) lut[lut_waddr] <= lut_wdata;
            if (push) stk[SA_W'(sp)] <= pc_inc;
        end
    end
    always_comb begin
        state_n = state;
        pc_n    = PC;
        sp_n    = sp;
        push    = 1'b0;
        if (state != RUN) begin
            if (start) begin
                state_n = RUN;
                pc_n    = '0;
                sp_n    = '0;
            end
        end else if (!stall) begin
            if (halt) begin
                state_n = DONE;
            end else if (ret) begin
                if (sp == '0) begin
                    state_n = FAULT;
                end else begin
                    pc_n = stk[SA_W'(sp - 1'b1)];
                    sp_n = sp - 1'b1;
                end
            end else if (call) begin
                if (sp == SP_W'(STK_DEPTH)) begin
                    state_n = FAULT;
                end else begin
                    push = 1'b1;
                    pc_n = tgt;
                    sp_n = sp + 1'b1;
                end
            end else if (br_abs) begin
                pc_n = z ? tgt : pc_inc;
            end else if (br_rel) begin
                pc_n = z ? PC + tgt : pc_inc;
            end else begin
                pc_n = pc_inc;
            end
        end
    end
    always_comb begin
        running = state == RUN;
        done    = state == DONE || state == FAULT;
        err     = state == FAULT;
    end
endmodule

// File: tb/tb_pc_seq_stack.sv
// tb_pc_seq_stack: directed and randomized checks of pc_seq_stack against a queue-based model
module tb_pc_seq_stack;
    logic clk = 0, reset = 0, start = 0, stall = 0, br_rel = 0, br_abs = 0;
    logic call = 0, ret = 0, halt = 0, z = 0, lut_we = 0;
    logic [1:0] sel = 0, lut_waddr = 0;
    logic [7:0] lut_wdata = 0;
    logic [7:0] PC;
    logic running, done, err;
    logic [2:0] sp_lvl;
    int ncmp = 0, nfail = 0;
    int mst;
    logic [7:0] mpc;
    logic [7:0] mlut [4];
    logic [7:0] mstk [$];

    always #5 clk = ~clk;

    pc_seq_stack dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .br_rel(br_rel),
        .br_abs(br_abs), .call(call), .ret(ret), .halt(halt), .sel(sel), .z(z),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .PC(PC), .running(running), .done(done), .err(err), .sp_lvl(sp_lvl)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", 32'(PC), 32'(mpc));
        chk("running", 32'(running), 32'(mst == 1));
        chk("done", 32'(done), 32'(mst >= 2));
        chk("err", 32'(err), 32'(mst == 3));
        chk("sp_lvl", 32'(sp_lvl), 32'(mstk.size()));
    endtask

    task automatic model_reset();
        mst = 0;
        mpc = 0;
        mstk.delete();
        foreach (mlut[i]) mlut[i] = 0;
    endtask

    // states: 0 idle, 1 run, 2 done, 3 fault
    task automatic model_step();
        logic [7:0] t;
        t = mlut[sel];
        if (mst != 1) begin
            if (start) begin
                mst = 1;
                mpc = 0;
                mstk.delete();
            end
        end else if (!stall) begin
            if (halt) mst = 2;
            else if (ret) begin
                if (mstk.size() == 0) mst = 3;
                else mpc = mstk.pop_back();
            end else if (call) begin
                if (mstk.size() == 4) mst = 3;
                else begin
                    mstk.push_back(mpc + 8'd1);
                    mpc = t;
                end
            end else if (br_abs) mpc = z ? t : mpc + 8'd1;
            else if (br_rel) mpc = z ? mpc + t : mpc + 8'd1;
            else mpc = mpc + 8'd1;
        end
        if (lut_we) mlut[lut_waddr] = lut_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic clr();
        {start, stall, br_rel, br_abs, call, ret, halt, z, lut_we} = '0;
        sel = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        check_all();
    endtask

    task automatic lutw(input logic [1:0] a, input logic [7:0] d);
        lut_we = 1; lut_waddr = a; lut_wdata = d;
        tick();
        lut_we = 0;
    endtask

    task automatic goto_pc(input int n);
        clr(); halt = 1; tick();
        clr(); start = 1; tick();
        clr();
        repeat (n) tick();
    endtask

    initial begin
        model_reset();
        do_reset();
        chk("reset_pc", 32'(PC), 0);
        chk("reset_running", 32'(running), 0);
        start = 1; tick(); start = 0;
        chk("start_pc0", 32'(PC), 0);
        chk("start_running", 32'(running), 1);
        repeat (255) tick();
        chk("pc_255", 32'(PC), 32'hFF);
        tick();
        chk("pc_wrap", 32'(PC), 0);
        chk("wrap_done", 32'(done), 0);
        repeat (3) tick();

        do_reset();
        lutw(1, 8'h20); lutw(2, 8'hFC); lutw(0, 8'h40); lutw(3, 8'h80);
        goto_pc(5);
        chk("at5", 32'(PC), 5);
        br_abs = 1; sel = 1; z = 1; tick(); clr();
        chk("br_abs_taken", 32'(PC), 32'h20);
        goto_pc(5);
        br_abs = 1; sel = 1; z = 0; tick(); clr();
        chk("br_abs_not_taken", 32'(PC), 6);
        goto_pc(16);
        br_rel = 1; sel = 2; z = 1; tick(); clr();
        chk("br_rel_back", 32'(PC), 32'h0C);

        goto_pc(3);
        call = 1; sel = 0; tick();
        chk("call1_pc", 32'(PC), 32'h40); chk("call1_sp", 32'(sp_lvl), 1);
        sel = 3; tick(); clr();
        chk("call2_pc", 32'(PC), 32'h80); chk("call2_sp", 32'(sp_lvl), 2);
        ret = 1; tick();
        chk("ret1_pc", 32'(PC), 32'h41); chk("ret1_sp", 32'(sp_lvl), 1);
        tick(); clr();
        chk("ret2_pc", 32'(PC), 4); chk("ret2_sp", 32'(sp_lvl), 0);

        goto_pc(0);
        call = 1; sel = 0;
        repeat (5) tick();
        clr();
        chk("ovf_err", 32'(err), 1); chk("ovf_done", 32'(done), 1);
        chk("ovf_sp", 32'(sp_lvl), 4); chk("ovf_pc", 32'(PC), 32'h40);
        tick();
        chk("ovf_hold_pc", 32'(PC), 32'h40);
        start = 1; tick(); clr();
        chk("restart_pc", 32'(PC), 0); chk("restart_sp", 32'(sp_lvl), 0);
        chk("restart_err", 32'(err), 0);
        ret = 1; tick(); clr();
        chk("unf_err", 32'(err), 1); chk("unf_sp", 32'(sp_lvl), 0);

        start = 1; tick(); clr();
        repeat (2) tick();
        call = 1; sel = 0; tick(); clr();
        halt = 1; call = 1; br_abs = 1; z = 1; sel = 3; tick(); clr();
        chk("halt_done", 32'(done), 1); chk("halt_err", 32'(err), 0);
        chk("halt_pc", 32'(PC), 32'h40); chk("halt_sp", 32'(sp_lvl), 1);
        start = 1; tick(); clr();
        stall = 1; br_abs = 1; sel = 1; z = 1;
        repeat (3) tick();
        chk("stall_pc", 32'(PC), 0);
        stall = 0; tick(); clr();
        chk("unstall_pc", 32'(PC), 32'h20);

        goto_pc(0);
        br_abs = 1; sel = 1; z = 1; lut_we = 1; lut_waddr = 1; lut_wdata = 8'h55;
        tick(); clr();
        chk("lut_old", 32'(PC), 32'h20);
        br_abs = 1; sel = 1; z = 1; tick(); clr();
        chk("lut_new", 32'(PC), 32'h55);
        repeat (2) tick();
        do_reset();
        chk("midrst_pc", 32'(PC), 0); chk("midrst_running", 32'(running), 0);
        start = 1; tick(); clr();
        br_abs = 1; sel = 1; z = 1; tick(); clr();
        chk("lut_cleared", 32'(PC), 0);

        for (int n = 0; n < 3000; n++) begin
            start  = $urandom_range(0, 99) < 6;
            stall  = $urandom_range(0, 99) < 20;
            halt   = $urandom_range(0, 99) < 2;
            ret    = $urandom_range(0, 99) < 12;
            call   = $urandom_range(0, 99) < 14;
            br_abs = $urandom_range(0, 99) < 15;
            br_rel = $urandom_range(0, 99) < 15;
            z      = 1'($urandom);
            sel    = 2'($urandom);
            lut_we = $urandom_range(0, 99) < 10;
            lut_waddr = 2'($urandom);
            lut_wdata = 8'($urandom);
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick();
        end
        clr();
        $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/pc_seq_stack.md
Name: pc_seq_stack

Overview:
Parametrised program sequencer for the next-generation core. It replaces the fixed PC plus 2-bit branch LUT pair with a sequencer that adds the following:
- a programmable branch-target LUT
- relative and absolute conditional branches
- call/return through a hardware return stack
- a start/done run handshake with fault reporting

It sits between the decoder (control strobes, zero flag) and instruction memory (PC).

Parameters:
PC_W, 8, program counter width; PC arithmetic wraps modulo 2^PC_W
LUT_AW, 2, LUT address width; LUT holds 2^LUT_AW entries of PC_W bits
STK_DEPTH, 4, return-stack entries (>=1)
SP_W, $clog2(STK_DEPTH+1), stack-level width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin execution at PC=0 (accepted in IDLE, DONE, FAULT)
stall  in  1  hold PC/stack/state this cycle (RUN only)
br_rel  in  1  branch relative if z
br_abs  in  1  branch absolute if z
call  in  1  push PC+1, jump to lut[sel]
ret  in  1  pop PC
halt  in  1  stop execution
sel  in  LUT_AW  LUT entry for br_rel/br_abs/call
z  in  1  ALU zero flag
lut_we  in  1  LUT write strobe
lut_waddr  in  LUT_AW  LUT write address
lut_wdata  in  PC_W  LUT write data
PC  out  PC_W  program counter to instruction memory
running  out  1  high in RUN
done  out  1  high in DONE or FAULT
err  out  1  high in FAULT
sp_lvl  out  SP_W  current stack occupancy

Behaviour:
Reset (reset=0, asynchronous):
- state=IDLE, PC=0, sp=0, all LUT entries=0, stack contents=0.
- running=0, done=0, err=0.

States: IDLE, RUN, DONE, FAULT. All outputs are registered or decoded from registered state.

- IDLE: PC=0. start -> RUN next cycle; PC stays 0, so the first fetched instruction is at 0.
- RUN with stall=1: nothing changes.
- RUN with stall=0: evaluate in this priority order: halt > ret > call > br_abs > br_rel > sequential.
  - halt: -> DONE; PC holds.
  - ret with sp==0: -> FAULT (underflow); PC holds.
  - ret with sp>0: PC <= stack[sp-1]; sp <= sp-1.
  - call with sp==STK_DEPTH: -> FAULT (overflow); PC holds.
  - call with sp<STK_DEPTH: stack[sp] <= PC+1 (wrapped); sp <= sp+1; PC <= lut[sel].
  - br_abs with z=1: PC <= lut[sel]. With z=0: PC <= PC+1.
  - br_rel with z=1: PC <= PC + lut[sel]. The LUT entry is read as two's complement, the sum is modulo 2^PC_W, and no overflow is flagged. With z=0: PC <= PC+1.
  - Otherwise: PC <= PC+1. 2^PC_W-1 wraps to 0.
- DONE: done=1; PC holds. start -> RUN with PC=0, sp=0 (restart).
- FAULT: done=1, err=1; PC and sp hold for debug. start -> RUN with PC=0, sp=0, err cleared.
- start while in RUN: ignored.

LUT:
- Synchronous write, enabled in every state.
- Read is combinational from stored contents. A write and a use of the same entry in one cycle uses the old value; the new value is visible the next cycle.

Other rules:
- halt/ret/call/br_* are ignored outside RUN.
- sp_lvl always equals the current sp.
- Reset asserted mid-run returns to IDLE immediately and clears the LUT.

Test Plan:
1. Reset, then start with no strobes for 260 cycles -> PC counts 0..255, wraps to 0; running=1, done=0.
2. lut[1]=8'h20; at PC=5 assert br_abs, sel=1, z=1 -> PC=8'h20. Repeat with z=0 -> PC=6. lut[2]=8'hFC, br_rel at PC=8'h10 with z=1 -> PC=8'h0C.
3. lut[0]=8'h40, lut[3]=8'h80. Call sel=0 at PC=3 -> PC=8'h40, sp=1. Call sel=3 -> PC=8'h80, sp=2. Ret -> PC=8'h41, sp=1. Ret -> PC=4, sp=0.
4. Five consecutive calls with STK_DEPTH=4 -> 5th enters FAULT: err=1, done=1, sp_lvl=4, PC holds. Start -> PC=0, sp=0, err=0. Ret with sp=0 -> FAULT.
5. Halt together with call and br_abs -> DONE; PC and sp unchanged. Stall=1 held 3 cycles with br_abs, z=1 -> PC frozen, then jumps once stall drops.
6. lut_we to entry 1 in the same cycle as br_abs sel=1 -> old target used. Reset pulsed mid-RUN -> PC=0, IDLE, LUT=0 asynchronously.
